// File: rtl/mvm_pkg.sv
// Shared types and constants for the MVM job scheduler and its lane accumulators.
package mvm_pkg;

    localparam int LANES = 4;
    localparam int BN_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_ACCUM,
        ST_DONE
    } msch_state_t;

endpackage

// File: rtl/msch_lane_acc.sv
// One signed accumulator lane: clear, add a sign-extended BN_W result, wrap or clamp.
// Define MSCH_SATURATE_EN to clamp at the signed ACC_W limits instead of wrapping.
module msch_lane_acc
    import mvm_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    add_en_i,
    input  logic signed [BN_W-1:0]  val_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;

`ifdef MSCH_SATURATE_EN
    // One guard bit exposes overflow; the guard's sign picks the limit.
    function automatic logic signed [ACC_W-1:0] add_lane(
        input logic signed [ACC_W-1:0] a,
        input logic signed [BN_W-1:0]  b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W + 1 - BN_W){b[BN_W-1]}}, b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        end
        return s[ACC_W-1:0];
    endfunction
`else
    function automatic logic signed [ACC_W-1:0] add_lane(
        input logic signed [ACC_W-1:0] a,
        input logic signed [BN_W-1:0]  b
    );
        return a + {{(ACC_W - BN_W){b[BN_W-1]}}, b};
    endfunction
`endif

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_en_i) begin
            acc_d = add_lane(acc_q, val_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mvm_sched.sv
// Job scheduler: issues one MVM per non-zero weight and accumulates 4 lane results.
// Define MSCH_SATURATE_EN to make the lane accumulators saturate instead of wrap.
module mvm_sched
    import mvm_pkg::*;
#(
    parameter int N_W      = 4,
    parameter int ACC_W    = 8,
    parameter int WAIT_TMO = 16
) (
    input  logic                        i_clk_msch,
    input  logic                        i_rst_msch,
    input  logic                        i_job_valid,
    output logic                        o_job_ready,
    input  logic [LANES-1:0][BN_W-1:0]  i_x_bn,
    input  logic [N_W-1:0][BN_W-1:0]    i_w_msch,
    output logic                        o_start_mvm,
    output logic [BN_W-1:0]             o_w_mvm,
    output logic [LANES-1:0][BN_W-1:0]  o_x_mvm,
    input  logic                        i_ismvm,
    input  logic [LANES-1:0][BN_W-1:0]  i_wx_result,
    output logic                        o_res_valid,
    input  logic                        i_res_ready,
    output logic [LANES-1:0][ACC_W-1:0] o_acc_result,
    output logic                        o_busy,
    output logic                        o_err
);

    localparam int IDX_W = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int CNT_W = $clog2(WAIT_TMO + 1);

    msch_state_t                 state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [IDX_W-1:0]            idx_nxt;
    logic [CNT_W-1:0]            cnt_q;
    logic [N_W-1:0][BN_W-1:0]    w_q;
    logic [LANES-1:0][BN_W-1:0]  x_q;
    logic [LANES-1:0][BN_W-1:0]  res_q;
    logic [BN_W-1:0]             w_mvm_q;
    logic                        start_q;
    logic                        job_ready_q;
    logic                        res_valid_q;
    logic                        busy_q;
    logic                        err_q;
    logic                        acc_clr;
    logic                        acc_add;

    assign idx_nxt = idx_q + IDX_W'(1);
    assign acc_clr = (state_q == ST_IDLE) && i_job_valid && job_ready_q;
    assign acc_add = (state_q == ST_ACCUM);

    // The weight and start pulse are loaded on entry to ISSUE so the pulse lines up with that state.
    always_ff @(posedge i_clk_msch or negedge i_rst_msch) begin
        if (!i_rst_msch) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            w_q         <= '0;
            x_q         <= '0;
            res_q       <= '0;
            w_mvm_q     <= '0;
            start_q     <= 1'b0;
            job_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_job_valid && job_ready_q) begin
                        x_q         <= i_x_bn;
                        w_q         <= i_w_msch;
                        idx_q       <= '0;
                        cnt_q       <= '0;
                        w_mvm_q     <= i_w_msch[0];
                        start_q     <= (i_w_msch[0] != '0);
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= '0;
                    if (w_mvm_q != '0) begin
                        state_q <= ST_WAIT_HI;
                    end else begin
                        res_q   <= '0;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_WAIT_HI: begin
                    if (i_ismvm) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_LO;
                    end else if (cnt_q == CNT_W'(WAIT_TMO - 1)) begin
                        err_q   <= 1'b1;
                        res_q   <= '0;
                        state_q <= ST_ACCUM;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LO: begin
                    if (!i_ismvm) begin
                        res_q   <= i_wx_result;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (idx_q == IDX_W'(N_W - 1)) begin
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q   <= idx_nxt;
                        w_mvm_q <= w_q[idx_nxt];
                        start_q <= (w_q[idx_nxt] != '0);
                        state_q <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    if (i_res_ready) begin
                        res_valid_q <= 1'b0;
                        job_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        msch_lane_acc #(
            .ACC_W(ACC_W)
        ) u_lane (
            .clk_i   (i_clk_msch),
            .rst_ni  (i_rst_msch),
            .clr_i   (acc_clr),
            .add_en_i(acc_add),
            .val_i   (res_q[l]),
            .acc_o   (o_acc_result[l])
        );
    end

    assign o_job_ready = job_ready_q;
    assign o_start_mvm = start_q;
    assign o_w_mvm     = w_mvm_q;
    assign o_x_mvm     = x_q;
    assign o_res_valid = res_valid_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;

endmodule

// File: doc/mvm_sched.md
MVM_SCHED -- requirements
Module: mvm_sched

Interface
REQ-001 SHALL have parameter N_W, default 4: weights per job, range 1..16.
REQ-002 SHALL have parameter ACC_W, default 8: signed accumulator width per lane, minimum 6.
REQ-003 SHALL have parameter WAIT_TMO, default 16: maximum cycles to wait for i_ismvm to rise.
REQ-004 SHALL have port i_clk_msch, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_msch, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_job_valid, input, 1: job offered.
REQ-007 SHALL have port o_job_ready, output, 1: scheduler can accept a job.
REQ-008 SHALL have port i_x_bn, input, 4x4: 4-bit BN activations, lanes 0..3.
REQ-009 SHALL have port i_w_msch, input, N_Wx4: unsigned 4-bit weights, index 0 first.
REQ-010 SHALL have port o_start_mvm, output, 1: one-cycle start pulse to the MVM datapath.
REQ-011 SHALL have port o_w_mvm, output, 4: current weight to the MVM.
REQ-012 SHALL have port o_x_mvm, output, 4x4: latched activations to the MVM.
REQ-013 SHALL have port i_ismvm, input, 1: MVM generation-active flag.
REQ-014 SHALL have port i_wx_result, input, 4x4: per-lane MVM results, 4-bit two's complement.
REQ-015 SHALL have port o_res_valid, output, 1: accumulated result available.
REQ-016 SHALL have port i_res_ready, input, 1: consumer accepts the result.
REQ-017 SHALL have port o_acc_result, output, 4xACC_W: signed per-lane sums.
REQ-018 SHALL have port o_busy, output, 1: high in every state except IDLE.
REQ-019 SHALL have port o_err, output, 1: sticky timeout flag.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT_HI, WAIT_LO, ACCUM, DONE.
REQ-021 IDLE: o_job_ready=1; on i_job_valid, SHALL latch x and all weights, clear accumulators, set idx=0, go to ISSUE.
REQ-022 ISSUE: if w[idx]!=0, SHALL drive o_start_mvm=1 for exactly one cycle with o_w_mvm=w[idx], then go to WAIT_HI; if w[idx]==0, SHALL go directly to ACCUM with zero contribution and no start pulse.
REQ-023 WAIT_HI: on i_ismvm=1, SHALL go to WAIT_LO; after WAIT_TMO cycles without a rise, SHALL set o_err and go to ACCUM with zero contribution.
REQ-024 WAIT_LO: on i_ismvm=0, SHALL sample i_wx_result in that cycle and go to ACCUM.
REQ-025 ACCUM: SHALL add the sign-extended lane results to the accumulators in one cycle; if idx==N_W-1, go to DONE, else idx++ and go to ISSUE.
REQ-026 DONE: SHALL hold o_res_valid=1 and o_acc_result stable until i_res_ready=1, then go to IDLE; o_res_valid SHALL drop the following cycle.
REQ-027 o_w_mvm and o_x_mvm SHALL be registered and stay stable from ISSUE through WAIT_LO.
REQ-028 i_job_valid outside IDLE SHALL be ignored; a job SHALL be accepted only when i_job_valid and o_job_ready are both high.
REQ-029 Accumulator overflow SHALL wrap modulo 2^ACC_W unless MSCH_SATURATE_EN is defined.
REQ-030 o_err SHALL clear only on reset.

Reset
REQ-031 Asserting i_rst_msch low at any time, including mid-job, SHALL immediately force the state to IDLE.
REQ-032 Reset SHALL set all outputs to 0 except o_job_ready, which SHALL be 1, and SHALL clear the accumulators, idx, and the timeout counter.

Configuration
REQ-033 With MSCH_SATURATE_EN defined, each accumulator SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-034 With MSCH_SATURATE_EN undefined, accumulators SHALL wrap and no clamp logic SHALL exist.

Structure
REQ-035 Package mvm_pkg SHALL hold the state enum msch_state_t and the constants LANES=4 and BN_W=4.
REQ-036 Sub-module msch_lane_acc SHALL implement one lane (clear, add-enable, optional saturation) and be instantiated 4 times.

Verification
REQ-037 N_W=2, w={3,2}, model pulses i_ismvm for 3 cycles with results {1,-1,2,0} per weight -> o_acc_result={2,-2,4,0}, exactly 2 start pulses, o_res_valid asserted.
REQ-038 w={0,0,0,0} -> no o_start_mvm, DONE reached with result {0,0,0,0}.
REQ-039 i_ismvm held low after start -> o_err=1 after 16 cycles, job completes with zero contribution for that weight.
REQ-040 ACC_W=6, lane result 7 repeated 16 times -> wraps to -16 without the macro; saturates at 31 with MSCH_SATURATE_EN.
REQ-041 i_res_ready held low for 10 cycles in DONE -> o_res_valid and o_acc_result stable; a second i_job_valid is ignored.
REQ-042 Reset asserted while in WAIT_LO -> IDLE next edge, o_busy=0, o_job_ready=1, accumulators 0.
